// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO stream reader (2-entry skid buffer).
package fifo_rd_pkg;
  localparam int DW_DEF    = 8;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream; master = the reader.
interface fifo_stream_reader_if
  import fifo_rd_pkg::*;
#(
  parameter int DW = DW_DEF
) ();
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (input fifo_empty, fifo_dout, m_ready, output fifo_rd, m_valid, m_data);
  modport slave  (output fifo_empty, fifo_dout, m_ready, input fifo_rd, m_valid, m_data);
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head is always the presented word, tail absorbs one
// extra word while the consumer stalls.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);
  buf_state_t    state, state_nxt;
  logic [DW-1:0] head, tail;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Simultaneous push/pop in ONE replaces the head; TWO never sees a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) head <= din;
        ONE: begin
          if (push && pop) head <= din;
          else if (push)   tail <= din;
        end
        TWO:     if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_comb begin
    valid = (state != EMPTY);
    dout  = head;
    unique case (state)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a 1-cycle-latency sync FIFO, re-presenting words as
// a valid/ready stream. FIFO_RD_STATS_EN adds pop and stall counters.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
`ifdef FIFO_RD_STATS_EN
  output logic [15:0] words_out,
  output logic [15:0] stall_cnt,
`endif
  fifo_stream_reader_if.master bus
);
  if (RD_LAT != 1) begin : g_rd_lat_bad
    $error("fifo_stream_reader: RD_LAT=%0d unsupported, only 1", RD_LAT);
  end

  logic       inflight, pop;
  logic [1:0] occ;
  logic [2:0] load;

  assign pop = bus.m_valid && bus.m_ready;
  // Words already owned after this edge; a new read must still find a slot.
  assign load        = 3'(occ) + 3'(inflight) - 3'(pop);
  assign bus.fifo_rd = en && !bus.fifo_empty && !rst && (load < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= bus.fifo_rd;
  end

  fifo_rd_skid #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (bus.fifo_dout),
    .pop   (pop),
    .valid (bus.m_valid),
    .dout  (bus.m_data),
    .occ   (occ)
  );

  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    (3'(occ) + 3'(inflight)) <= 3'(BUF_DEPTH));

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      words_out <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop)                          words_out <= words_out + 16'd1;
      if (bus.m_valid && !bus.m_ready)  stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural 16x8 sync FIFO feeding fifo_stream_reader.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, wr = 1'b0, fclr = 1'b0, rdy = 1'b0;
  logic [7:0] wdata = 8'h00;

  fifo_stream_reader_if #(.DW(8)) bus ();
`ifdef FIFO_RD_STATS_EN
  logic [15:0] words_out, stall_cnt;
`endif

  fifo_stream_reader #(.DW(8), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef FIFO_RD_STATS_EN
    .words_out (words_out),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  // FIFO model: dout registered one cycle after rd
  logic [7:0] fmem [16];
  logic [3:0] wp = 4'd0, rp = 4'd0;
  logic [4:0] fcnt = 5'd0;
  assign bus.fifo_empty = (fcnt == 5'd0);
  assign bus.m_ready    = rdy;

  always @(posedge clk) begin
    if (fclr) begin
      wp <= 4'd0; rp <= 4'd0; fcnt <= 5'd0;
    end else begin
      if (bus.fifo_rd) begin bus.fifo_dout <= fmem[rp]; rp <= rp + 4'd1; end
      if (wr)          begin fmem[wp] <= wdata;        wp <= wp + 4'd1; end
      fcnt <= fcnt + 5'(wr) - 5'(bus.fifo_rd);
    end
  end

  // Monitor: only this process writes these
  int         rd_cnt = 0, rd_empty = 0, vcnt = 0;
  logic [7:0] got [$];
  always @(negedge clk) begin
    if (bus.fifo_rd) begin
      rd_cnt++;
      if (bus.fifo_empty) rd_empty++;
    end
    if (bus.m_valid) vcnt++;
    if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
  end

  int errors = 0, checks = 0;
  int b_rd, b_got, b_v, b_re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(); wr = 1'b1; wdata = first + 8'(i);
    end
    cyc(); wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with 3 words waiting: nothing may be read
    load(8'h31, 3);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rst_rd",    32'(bus.fifo_rd), 0);
      chk("rst_valid", 32'(bus.m_valid), 0);
      chk("rst_data",  32'(bus.m_data),  0);
      cyc();
    end
    chk("rst_fifo_keep", 32'(fcnt), 3);
`ifdef FIFO_RD_STATS_EN
    chk("rst_words", 32'(words_out), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
`endif
    en = 1'b0; rst = 1'b0; fclr = 1'b1;
    cyc(); fclr = 1'b0;

    // Streaming 0x11..0x1F, m_ready=1
    load(8'h11, 15);
    b_rd = rd_cnt;
    rdy = 1'b1; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic ev;
      mid();
      ev = (i >= 2 && i <= 16);
      chk("stream_valid", 32'(bus.m_valid), 32'(ev));
      if (ev) chk("stream_data", 32'(bus.m_data), 32'(8'h11 + 8'(i - 2)));
    end
    chk("stream_reads", 32'(rd_cnt - b_rd), 15);
    chk("stream_rd_empty", 32'(rd_empty), 0);
    cyc(); en = 1'b0; rdy = 1'b0;

    // Backpressure: 5 words, m_ready=0 for 10 cycles
    load(8'h11, 5);
    b_rd = rd_cnt;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (i >= 2) begin
        chk("bp_valid", 32'(bus.m_valid), 1);
        chk("bp_hold",  32'(bus.m_data),  32'h11);
      end
    end
    chk("bp_reads", 32'(rd_cnt - b_rd), 2);
    chk("bp_fifo_keep", 32'(fcnt), 3);
    cyc();
    b_got = got.size();
    rdy = 1'b1;
    repeat (12) cyc();
    chk("bp_count", 32'(got.size() - b_got), 5);
    for (int k = 0; k < 5; k++)
      chk("bp_order", 32'(got[b_got + k]), 32'(8'h11 + 8'(k)));

    // Empty boundary: a single word 0xA5
    en = 1'b0;
    load(8'hA5, 1);
    b_rd = rd_cnt; b_got = got.size(); b_v = vcnt; b_re = rd_empty;
    en = 1'b1;
    repeat (8) cyc();
    chk("one_reads",    32'(rd_cnt - b_rd), 1);
    chk("one_rd_empty", 32'(rd_empty - b_re), 0);
    chk("one_vpulse",   32'(vcnt - b_v), 1);
    chk("one_count",    32'(got.size() - b_got), 1);
    chk("one_data",     32'(got[b_got]), 32'hA5);

    // en=0 holds reads off; reset right after a read drops that word
    en = 1'b0; rdy = 1'b0;
    load(8'h41, 4);
    b_rd = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("en0_rd", 32'(bus.fifo_rd), 0);
    end
    cyc(); en = 1'b1;
    cyc(); rst = 1'b1;
    mid();
    chk("rst_gates_rd", 32'(bus.fifo_rd), 0);
    cyc(); rst = 1'b0; en = 1'b0;
    mid();
    chk("drop_valid0", 32'(bus.m_valid), 0);
    cyc(); mid();
    chk("drop_valid1", 32'(bus.m_valid), 0);
    chk("drop_reads",  32'(rd_cnt - b_rd), 1);
    chk("drop_fifo",   32'(fcnt), 3);
    cyc();
    b_got = got.size();
    rdy = 1'b1; en = 1'b1;
    repeat (10) cyc();
    chk("drop_count", 32'(got.size() - b_got), 3);
    for (int k = 0; k < 3; k++)
      chk("drop_order", 32'(got[b_got + k]), 32'(8'h42 + 8'(k)));

`ifdef FIFO_RD_STATS_EN
    // Counters: clear on reset, then 8 pops with 3 stall cycles
    en = 1'b0; rdy = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    mid();
    chk("stats_clr_words", 32'(words_out), 0);
    chk("stats_clr_stall", 32'(stall_cnt), 0);
    cyc();
    load(8'h61, 8);
    en = 1'b1;
    repeat (5) cyc();
    rdy = 1'b1;
    repeat (20) cyc();
    chk("stats_words", 32'(words_out), 8);
    chk("stats_stall", 32'(stall_cnt), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
